// File: rtl/keysync_debounce.sv
// keysync_debounce: N-key two-flop synchroniser, highest-index priority encoder and code debouncer
// with a one-cycle accept strobe and a held level. Define KEYSYNC_REPEAT_EN for auto-repeat strobes.
module keysync_debounce #(
    parameter int unsigned  N_KEYS          = 20,
    parameter int unsigned  DEBOUNCE_CYCLES = 4,
    parameter int unsigned  REPEAT_CYCLES   = 16,
    localparam int unsigned W               = $clog2(N_KEYS),
    localparam int unsigned CW              = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] in,
    output logic [W-1:0]      out,
    output logic              strobe,
    output logic              held
);

    if (N_KEYS < 2) begin : g_chk_keys
        $error("keysync_debounce: N_KEYS must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $error("keysync_debounce: DEBOUNCE_CYCLES must be at least 2");
    end
    if (REPEAT_CYCLES < 2) begin : g_chk_rep
        $error("keysync_debounce: REPEAT_CYCLES must be at least 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    state_t              r_state;
    logic [N_KEYS-1:0]   r_s1;
    logic [N_KEYS-1:0]   r_s2;
    logic [CW-1:0]       r_cnt;
    logic [W-1:0]        r_cand;
    logic                w_any;
    logic [W-1:0]        w_code;

`ifdef KEYSYNC_REPEAT_EN
    localparam int unsigned   RW        = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]       r_rcnt;
`endif

    assign w_any = |r_s2;

    // Ascending scan so the highest set bit wins.
    always_comb begin
        w_code = '0;
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            if (r_s2[i]) begin
                w_code = W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_cand  <= '0;
            out     <= '0;
            strobe  <= 1'b0;
            held    <= 1'b0;
`ifdef KEYSYNC_REPEAT_EN
            r_rcnt  <= '0;
`endif
        end else begin
            r_s1   <= in;
            r_s2   <= r_s1;
            strobe <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state <= S_DEBOUNCE;
                        r_cand  <= w_code;
                        r_cnt   <= CW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!w_any) begin
                        r_state <= S_IDLE;
                    end else if (w_code != r_cand) begin
                        r_cand <= w_code;
                        r_cnt  <= CW'(1);
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_PRESSED;
                        out     <= r_cand;
                        strobe  <= 1'b1;
                        held    <= 1'b1;
`ifdef KEYSYNC_REPEAT_EN
                        r_rcnt  <= '0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_PRESSED: begin
                    if (!w_any || (w_code != out)) begin
                        r_state <= S_RELEASE;
                        r_cnt   <= CW'(1);
`ifdef KEYSYNC_REPEAT_EN
                        r_rcnt  <= '0;
                    end else if (r_rcnt == RCNT_LAST) begin
                        strobe <= 1'b1;
                        r_rcnt <= '0;
                    end else begin
                        r_rcnt <= r_rcnt + 1'b1;
`endif
                    end
                end
                S_RELEASE: begin
                    // A return of the accepted code is a bounce: back to PRESSED without a strobe.
                    if (w_any && (w_code == out)) begin
                        r_state <= S_PRESSED;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= S_IDLE;
                        held    <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
